// File: rtl/mips_defs.sv
// mips_defs: shared definitions for the multi-cycle MIPS control slice.
// Holds the opcode/funct constants, the datapath select encodings driven by
// mc_ctrl, the FSM state encoding, and the bit positions of the one-hot
// instruction-class vector produced by ctrl_decode.
package mips_defs;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // REGIMM rt field selecting bgez
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // ALU opcode
  localparam logic [1:0] ALUOP_ADD = 2'd0;
  localparam logic [1:0] ALUOP_SUB = 2'd1;
  localparam logic [1:0] ALUOP_OR  = 2'd2;
  localparam logic [1:0] ALUOP_SLT = 2'd3;

  // Next-PC source
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  // Immediate extender mode
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // GRF write-address source
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // GRF write-data source
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // FSM states; the encoding is visible on the debug state port
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Bit positions in the one-hot instruction-class vector
  localparam int CLS_ADDU = 0;
  localparam int CLS_SUBU = 1;
  localparam int CLS_SLT  = 2;
  localparam int CLS_JR   = 3;
  localparam int CLS_ORI  = 4;
  localparam int CLS_LUI  = 5;
  localparam int CLS_LW   = 6;
  localparam int CLS_SW   = 7;
  localparam int CLS_BEQ  = 8;
  localparam int CLS_BGEZ = 9;
  localparam int CLS_J    = 10;
  localparam int CLS_JAL  = 11;
  localparam int CLS_W    = 12;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction-class decoder.
// Ports:
//   opcode  in  6   IR[31:26]
//   funct   in  6   IR[5:0]
//   rt      in  5   IR[20:16]
//   iclass  out 12  one-hot class vector (bit positions CLS_* in mips_defs);
//                   all zero for an unsupported instruction
module ctrl_decode
  import mips_defs::*;
(
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rt,
  output logic [CLS_W-1:0] iclass
);

  // Exactly one bit is set for a supported instruction; an all-zero vector
  // is how the FSM recognises an illegal instruction.
  always_comb begin
    iclass = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass[CLS_ADDU] = 1'b1;
          FN_SUBU: iclass[CLS_SUBU] = 1'b1;
          FN_SLT:  iclass[CLS_SLT]  = 1'b1;
          FN_JR:   iclass[CLS_JR]   = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BGEZ) iclass[CLS_BGEZ] = 1'b1;
      end
      OP_J:    iclass[CLS_J]    = 1'b1;
      OP_JAL:  iclass[CLS_JAL]  = 1'b1;
      OP_BEQ:  iclass[CLS_BEQ]  = 1'b1;
      OP_ORI:  iclass[CLS_ORI]  = 1'b1;
      OP_LUI:  iclass[CLS_LUI]  = 1'b1;
      OP_LW:   iclass[CLS_LW]   = 1'b1;
      OP_SW:   iclass[CLS_SW]   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM.
// Sequences FETCH/DECODE/EXE/MEM/WB (plus BRANCH, JUMP, HALT) and drives the
// datapath strobes and selects. Outputs are combinational in state, IR fields
// and (in BRANCH only) the ALU flags; all are forced to 0 while reset is high.
// Parameter:
//   ILLEGAL_HALT  1: unknown instruction parks in HALT; 0: treated as a no-op
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   opcode, funct, rt           IR fields, stable between fetches
//   zero, bgez                  ALU flags
//   pc_wr, ir_wr, reg_wr, mem_wr  single-cycle write strobes
//   alu_op, alu_src_b, ext_op   ALU / extender control
//   reg_dst, mem_to_reg, npc_op GRF and next-PC selects
//   state                       current FSM state (debug)
//   illegal                     unknown instruction in DECODE, or HALT
module mc_ctrl
  import mips_defs::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       bgez,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic [1:0] ext_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] npc_op,
  output logic [2:0] state,
  output logic       illegal
);

  state_t           state_q;
  logic [CLS_W-1:0] iclass;
  logic             is_rtype_alu;
  logic             is_exe;
  logic             is_branch;
  logic             is_jump;
  logic             is_mem;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .rt     (rt),
    .iclass (iclass)
  );

  // Instruction groups that share a path through the FSM.
  assign is_rtype_alu = iclass[CLS_ADDU] | iclass[CLS_SUBU] | iclass[CLS_SLT];
  assign is_mem       = iclass[CLS_LW] | iclass[CLS_SW];
  assign is_exe       = is_rtype_alu | iclass[CLS_ORI] | iclass[CLS_LUI] | is_mem;
  assign is_branch    = iclass[CLS_BEQ] | iclass[CLS_BGEZ];
  assign is_jump      = iclass[CLS_J] | iclass[CLS_JAL] | iclass[CLS_JR];

  // State register. Reset wins from every state, so an in-flight instruction
  // is simply abandoned and the next cycle starts a fresh fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if (is_exe)              state_q <= S_EXE;
          else if (is_branch)      state_q <= S_BRANCH;
          else if (is_jump)        state_q <= S_JUMP;
          else if (ILLEGAL_HALT)   state_q <= S_HALT;
          else                     state_q <= S_FETCH;
        end
        S_EXE:    state_q <= is_mem ? S_MEM : S_WB;
        S_MEM:    state_q <= iclass[CLS_LW] ? S_WB : S_FETCH;
        S_WB:     state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign state = reset ? S_FETCH : state_q;

  // Output decode. Everything defaults to 0 and the reset gate keeps all
  // strobes low in the cycle a reset arrives, even mid-instruction.
  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_src_b  = 1'b0;
    ext_op     = EXT_ZERO;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALU;
    npc_op     = NPC_PC4;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        S_DECODE: illegal = ~(|iclass);
        S_EXE: begin
          if (iclass[CLS_SUBU]) alu_op = ALUOP_SUB;
          if (iclass[CLS_SLT])  alu_op = ALUOP_SLT;
          if (iclass[CLS_ORI] | iclass[CLS_LUI]) begin
            alu_op    = ALUOP_OR;
            alu_src_b = 1'b1;
            ext_op    = iclass[CLS_LUI] ? EXT_LUI : EXT_ZERO;
          end
          if (is_mem) begin
            alu_src_b = 1'b1;
            ext_op    = EXT_SIGN;
          end
        end
        S_MEM: mem_wr = iclass[CLS_SW];
        S_WB: begin
          reg_wr     = 1'b1;
          reg_dst    = is_rtype_alu ? REGDST_RD : REGDST_RT;
          mem_to_reg = iclass[CLS_LW] ? M2R_MEM : M2R_ALU;
        end
        S_BRANCH: begin
          // The ALU subtracts rs-rt; the flags decide whether the target is taken.
          alu_op = ALUOP_SUB;
          ext_op = EXT_SIGN;
          npc_op = NPC_BRANCH;
          pc_wr  = (iclass[CLS_BEQ] & zero) | (iclass[CLS_BGEZ] & bgez);
        end
        S_JUMP: begin
          pc_wr = 1'b1;
          if (iclass[CLS_JR]) begin
            npc_op = NPC_JR;
          end else begin
            npc_op = NPC_JUMP;
          end
          // jal links PC+4 into $31 in the same cycle the PC is redirected;
          // the datapath's PC+4 still reflects the pre-update PC here.
          if (iclass[CLS_JAL]) begin
            reg_wr     = 1'b1;
            reg_dst    = REGDST_RA;
            mem_to_reg = M2R_PC4;
          end
        end
        S_HALT:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Two instances share all
// inputs: dut0 treats illegal opcodes as no-ops, dut1 halts on them.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] npc_op;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic       z;
    logic       b;
    outs_t      exp;
  } vec_t;

  typedef struct {
    string name;
    outs_t e0;
    outs_t e1;
  } sb_t;

  localparam int OP_R    = 'b000000;
  localparam int OP_RI   = 'b000001;
  localparam int OP_J    = 'b000010;
  localparam int OP_JAL  = 'b000011;
  localparam int OP_BEQ  = 'b000100;
  localparam int OP_ORI  = 'b001101;
  localparam int OP_LUI  = 'b001111;
  localparam int OP_LW   = 'b100011;
  localparam int OP_SW   = 'b101011;
  localparam int OP_BAD  = 'b111111;
  localparam int FN_ADDU = 'b100001;
  localparam int FN_SUBU = 'b100011;
  localparam int FN_SLT  = 'b101010;
  localparam int FN_JR   = 'b001000;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       zero;
  logic       bgez;

  logic       pc_wr0, ir_wr0, reg_wr0, mem_wr0, alu_src_b0, illegal0;
  logic [1:0] alu_op0, ext_op0, reg_dst0, mem_to_reg0, npc_op0;
  logic [2:0] state0;
  logic       pc_wr1, ir_wr1, reg_wr1, mem_wr1, alu_src_b1, illegal1;
  logic [1:0] alu_op1, ext_op1, reg_dst1, mem_to_reg1, npc_op1;
  logic [2:0] state1;

  outs_t act0, act1;
  assign act0 = {state0, pc_wr0, ir_wr0, reg_wr0, mem_wr0, alu_op0, alu_src_b0,
                 ext_op0, reg_dst0, mem_to_reg0, npc_op0, illegal0};
  assign act1 = {state1, pc_wr1, ir_wr1, reg_wr1, mem_wr1, alu_op1, alu_src_b1,
                 ext_op1, reg_dst1, mem_to_reg1, npc_op1, illegal1};

  vec_t vecs[$];
  sb_t  sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  string      curName;
  logic [5:0] curOp;
  logic [5:0] curFn;
  logic [4:0] curRt;
  logic       curZ;
  logic       curB;

  outs_t oZ, oF, oD, oDi, oH;

  always #5 clk = ~clk;

  mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rt(rt),
    .zero(zero), .bgez(bgez), .pc_wr(pc_wr0), .ir_wr(ir_wr0), .reg_wr(reg_wr0),
    .mem_wr(mem_wr0), .alu_op(alu_op0), .alu_src_b(alu_src_b0), .ext_op(ext_op0),
    .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .npc_op(npc_op0),
    .state(state0), .illegal(illegal0)
  );

  mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rt(rt),
    .zero(zero), .bgez(bgez), .pc_wr(pc_wr1), .ir_wr(ir_wr1), .reg_wr(reg_wr1),
    .mem_wr(mem_wr1), .alu_op(alu_op1), .alu_src_b(alu_src_b1), .ext_op(ext_op1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .npc_op(npc_op1),
    .state(state1), .illegal(illegal1)
  );

  // Builds an expected output record from plain integers.
  function automatic outs_t mk(int st, int pc, int ir, int rw, int mw, int aop,
                               int asb, int ext, int rd, int m2r, int npc, int ill);
    outs_t o;
    o.state      = st[2:0];
    o.pc_wr      = pc[0];
    o.ir_wr      = ir[0];
    o.reg_wr     = rw[0];
    o.mem_wr     = mw[0];
    o.alu_op     = aop[1:0];
    o.alu_src_b  = asb[0];
    o.ext_op     = ext[1:0];
    o.reg_dst    = rd[1:0];
    o.mem_to_reg = m2r[1:0];
    o.npc_op     = npc[1:0];
    o.illegal    = ill[0];
    return o;
  endfunction

  task automatic add(input string name, input int rst_i, input int op, input int fn,
                     input int rt_i, input int z, input int b, input outs_t e);
    vec_t v;
    v.name = name;
    v.rst  = rst_i[0];
    v.op   = op[5:0];
    v.fn   = fn[5:0];
    v.rt   = rt_i[4:0];
    v.z    = z[0];
    v.b    = b[0];
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Starts a new instruction in the table: its FETCH and DECODE cycles.
  task automatic setInstr(input string name, input int op, input int fn,
                          input int rt_i, input int z, input int b);
    curName = name;
    curOp   = op[5:0];
    curFn   = fn[5:0];
    curRt   = rt_i[4:0];
    curZ    = z[0];
    curB    = b[0];
    add({name, ".F"}, 0, op, fn, rt_i, z, b, oF);
    add({name, ".D"}, 0, op, fn, rt_i, z, b, oD);
  endtask

  task automatic nxt(input string tag, input outs_t e);
    add({curName, tag}, 0, int'(curOp), int'(curFn), int'(curRt), int'(curZ), int'(curB), e);
  endtask

  task automatic applyStimulus(input string name, input logic rst_i,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rt_i, input logic z, input logic b,
                               input outs_t e0, input outs_t e1);
    sb_t s;
    reset  = rst_i;
    opcode = op;
    funct  = fn;
    rt     = rt_i;
    zero   = z;
    bgez   = b;
    s.name = name;
    s.e0   = e0;
    s.e1   = e1;
    sb.push_back(s);
  endtask

  task automatic checkOutput();
    sb_t s;
    if (sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard empty at %0t", $time);
      return;
    end
    s = sb.pop_front();
    testsRun++;
    if (act0 !== s.e0) begin
      testsFailed++;
      $display("[TB] FAIL %s dut0 got %h expected %h", s.name, act0, s.e0);
    end
    testsRun++;
    if (act1 !== s.e1) begin
      testsFailed++;
      $display("[TB] FAIL %s dut1 got %h expected %h", s.name, act1, s.e1);
    end
  endtask

  // One clock cycle: drive, sample on the falling edge, advance past the rising edge.
  task automatic cycle(input string name, input int rst_i, input int op, input int fn,
                       input int rt_i, input int z, input int b,
                       input outs_t e0, input outs_t e1);
    applyStimulus(name, rst_i[0], op[5:0], fn[5:0], rt_i[4:0], z[0], b[0], e0, e1);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    outs_t eLS;
    outs_t eBr;
    outs_t eBrN;
    oZ   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    oF   = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    oD   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    oDi  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    oH   = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    eLS  = mk(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    eBr  = mk(5, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    eBrN = mk(5, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);

    // Vector table
    add("rst0", 1, 0, 0, 0, 0, 0, oZ);
    add("rst1", 1, 0, 0, 0, 0, 0, oZ);
    setInstr("addu", OP_R, FN_ADDU, 0, 0, 0);
    nxt(".E", mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nxt(".W", mk(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    setInstr("subu", OP_R, FN_SUBU, 0, 0, 0);
    nxt(".E", mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    nxt(".W", mk(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    setInstr("slt", OP_R, FN_SLT, 0, 0, 0);
    nxt(".E", mk(2, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    nxt(".W", mk(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    setInstr("ori", OP_ORI, 0, 0, 0, 0);
    nxt(".E", mk(2, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    nxt(".W", mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    setInstr("lui", OP_LUI, 0, 0, 0, 0);
    nxt(".E", mk(2, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0));
    nxt(".W", mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    setInstr("lw", OP_LW, 0, 0, 0, 0);
    nxt(".E", eLS);
    nxt(".M", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nxt(".W", mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    setInstr("sw", OP_SW, 0, 0, 0, 0);
    nxt(".E", eLS);
    nxt(".M", mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    setInstr("beqT", OP_BEQ, 0, 0, 1, 0);
    nxt(".B", eBr);
    setInstr("beqN", OP_BEQ, 0, 0, 0, 1);
    nxt(".B", eBrN);
    setInstr("bgezT", OP_RI, 0, 1, 0, 1);
    nxt(".B", eBr);
    setInstr("bgezN", OP_RI, 0, 1, 1, 0);
    nxt(".B", eBrN);
    setInstr("j", OP_J, 0, 0, 0, 0);
    nxt(".J", mk(6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    setInstr("jal", OP_JAL, 0, 0, 0, 0);
    nxt(".J", mk(6, 1, 0, 1, 0, 0, 0, 0, 2, 2, 2, 0));
    setInstr("jr", OP_R, FN_JR, 0, 0, 0);
    nxt(".J", mk(6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].name, int'(vecs[i].rst), int'(vecs[i].op), int'(vecs[i].fn),
            int'(vecs[i].rt), int'(vecs[i].z), int'(vecs[i].b), vecs[i].exp, vecs[i].exp);
    end

    // Illegal opcode: dut0 falls back to FETCH, dut1 parks in HALT until reset.
    cycle("ill.F",     0, OP_BAD, 0, 0, 0, 0, oF,  oF);
    cycle("ill.D",     0, OP_BAD, 0, 0, 0, 0, oDi, oDi);
    cycle("ill.next",  0, OP_BAD, 0, 0, 0, 0, oF,  oH);
    cycle("ill.hold1", 0, OP_BAD, 0, 0, 0, 0, oDi, oH);
    cycle("ill.hold2", 0, OP_BAD, 0, 0, 0, 0, oF,  oH);
    cycle("ill.rst",   1, OP_BAD, 0, 0, 0, 0, oZ,  oZ);
    cycle("ill.after", 0, OP_R, FN_ADDU, 0, 0, 0, oF, oF);
    cycle("ill.D2",    0, OP_R, FN_ADDU, 0, 0, 0, oD, oD);
    cycle("ill.E2",    0, OP_R, FN_ADDU, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
          mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle("ill.W2",    0, OP_R, FN_ADDU, 0, 0, 0, mk(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0),
          mk(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));

    // Reset landing in the MEM cycle of sw must suppress the store.
    cycle("abt.F",  0, OP_SW, 0, 0, 0, 0, oF,  oF);
    cycle("abt.D",  0, OP_SW, 0, 0, 0, 0, oD,  oD);
    cycle("abt.E",  0, OP_SW, 0, 0, 0, 0, eLS, eLS);
    cycle("abt.M",  1, OP_SW, 0, 0, 0, 0, oZ,  oZ);
    cycle("abt.F2", 0, OP_SW, 0, 0, 0, 0, oF,  oF);
    cycle("abt.D2", 0, OP_SW, 0, 0, 0, 0, oD,  oD);

    if (sb.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard leftover got %0d required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
